// File: rtl/sgpr_restore_pkg.sv
// Shared types for the SGPR restore sequencer: FSM state encoding and counter width.
package sgpr_restore_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    COPY  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4,
    FAIL  = 3'd5
  } state_t;

  localparam int RESTORE_CNT_W = 8;

endpackage

// File: rtl/sgpr_restore.sv
// Lockstep recovery sequencer: halts both cores, then copies x1..x(NUM_REGS-1) from
// the shared register file into both cores' local register files via one write port.
module sgpr_restore
  import sgpr_restore_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int HALT_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  output logic                     halt_o,
  input  logic                     halted_i,
  output logic [ADDR_WIDTH-1:0]    raddr_o,
  input  logic [DATA_WIDTH-1:0]    rdata_i,
  output logic                     we_o,
  output logic [ADDR_WIDTH-1:0]    waddr_o,
  output logic [DATA_WIDTH-1:0]    wdata_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     fail_o,
  output logic [RESTORE_CNT_W-1:0] restore_cnt_o,
  output logic [2:0]               dbg_state_o
);

  localparam int TIMER_W = $clog2(HALT_TIMEOUT + 1);
  localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(HALT_TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [TIMER_W-1:0]      timer;
  logic [ADDR_WIDTH-1:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_i) state_nxt = HALT;
      // The last non-acknowledged cycle is the one where the timer would reach HALT_TIMEOUT.
      HALT: begin
        if (halted_i)                 state_nxt = COPY;
        else if (timer == TIMER_LAST) state_nxt = FAIL;
      end
      COPY:  if (cnt == ADDR_LAST) state_nxt = DRAIN;
      DRAIN: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      FAIL:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer         <= '0;
      cnt           <= '0;
      we_o          <= 1'b0;
      waddr_o       <= '0;
      wdata_o       <= '0;
      restore_cnt_o <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        timer <= '0;
        cnt   <= ADDR_WIDTH'(1);
      end
      if (state == HALT && !halted_i) timer <= timer + 1'b1;
      if (state == COPY)              cnt   <= cnt + 1'b1;
      // Write port trails the read port by one cycle; address/data hold when idle.
      we_o <= (state == COPY);
      if (state == COPY) begin
        waddr_o <= cnt;
        wdata_o <= rdata_i;
      end
      if (state == DONE && restore_cnt_o != '1) restore_cnt_o <= restore_cnt_o + 1'b1;
    end
  end

  assign halt_o      = (state == HALT) || (state == COPY) || (state == DRAIN) || (state == DONE);
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign fail_o      = (state == FAIL);
  assign raddr_o     = (state == COPY) ? cnt : '0;
  assign dbg_state_o = state;

endmodule

// File: tb/tb_sgpr_restore.sv
// Randomized bench for sgpr_restore: per-cycle timing model plus write scoreboard.
module tb_sgpr_restore;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int HT = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          halt_o;
  logic          halted_i;
  logic [AW-1:0] raddr_o;
  logic [DW-1:0] rdata_i;
  logic          we_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;
  logic          busy_o;
  logic          done_o;
  logic          fail_o;
  logic [7:0]    restore_cnt_o;
  logic [2:0]    dbg_state;

  logic [DW-1:0]    mem [NR];
  logic [AW+DW-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  sgpr_restore #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .HALT_TIMEOUT(HT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .halt_o(halt_o), .halted_i(halted_i),
    .raddr_o(raddr_o), .rdata_i(rdata_i), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .restore_cnt_o(restore_cnt_o),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  assign rdata_i = mem[raddr_o];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".halt"}, halt_o, 0);
    check({tag, ".busy"}, busy_o, 0);
    check({tag, ".we"}, we_o, 0);
    check({tag, ".done"}, done_o, 0);
    check({tag, ".fail"}, fail_o, 0);
    check({tag, ".raddr"}, raddr_o, 0);
    check({tag, ".waddr"}, waddr_o, 0);
    check({tag, ".wdata"}, wdata_o, 0);
    check({tag, ".cnt"}, restore_cnt_o, 0);
  endtask

  task automatic fill_mem(input bit pattern);
    for (int n = 0; n < NR; n++)
      mem[n] = pattern ? (32'hA5A50000 + n) : $urandom;
  endtask

  // One restore attempt. d = cycles of HALT before acknowledge (d<0: never acknowledged).
  // spam drives start_i randomly while busy and forces it on the DONE cycle.
  // abort_at > 0 asserts reset when that write number is observed.
  task automatic run_restore(input int d, input bit spam, input int abort_at);
    int  last;
    int  nw;
    bit  e_halt, e_busy, e_we, e_done, e_fail;
    int  e_raddr;
    logic [AW+DW-1:0] obs;
    exp_q.delete();
    if (d >= 0)
      for (int n = 1; n < NR; n++) exp_q.push_back({AW'(n), mem[n]});
    last = (d < 0) ? HT + 2 : NR + 3 + d;
    nw = 0;
    @(negedge clk);
    start_i  = 1'b1;
    halted_i = 1'b0;
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      if (d >= 0) begin
        e_halt  = (t >= 1) && (t <= NR + 2 + d);
        e_busy  = e_halt;
        e_we    = (t >= 3 + d) && (t <= NR + 1 + d);
        e_done  = (t == NR + 2 + d);
        e_fail  = 1'b0;
        e_raddr = (t >= 2 + d && t <= NR + d) ? t - 1 - d : 0;
      end else begin
        e_halt  = (t >= 1) && (t <= HT);
        e_busy  = (t >= 1) && (t <= HT + 1);
        e_we    = 1'b0;
        e_done  = 1'b0;
        e_fail  = (t == HT + 1);
        e_raddr = 0;
      end
      check("halt", halt_o, e_halt);
      check("busy", busy_o, e_busy);
      check("we", we_o, e_we);
      check("done", done_o, e_done);
      check("fail", fail_o, e_fail);
      check("raddr", raddr_o, e_raddr);
      if (we_o) begin
        nw++;
        obs = {waddr_o, wdata_o};
        if (exp_q.size() == 0) check("unexpected_write", obs, 0);
        else check("write", obs, exp_q.pop_front());
        if (nw == abort_at) begin
          rst_n = 1'b0;
          #1;
          check_all_zero("async_reset");
          check("async_reset.state", dbg_state, 0);
          start_i  = 1'b0;
          halted_i = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          exp_cnt = 0;
          return;
        end
      end
      if (t == last) check("restore_cnt", restore_cnt_o, exp_cnt);
      // Drive inputs for the upcoming edge (end of cycle t).
      if (t >= last - 1) start_i = spam && (t == last - 1);
      else               start_i = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      if (d < 0)           halted_i = 1'b0;
      else if (t < 1 + d)  halted_i = 1'b0;
      else if (t == 1 + d) halted_i = 1'b1;
      else                 halted_i = spam ? 1'($urandom_range(0, 1)) : 1'b1;
      if (d >= 0 && t == NR + 2 + d) exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    end
    start_i  = 1'b0;
    halted_i = 1'b0;
    check("leftover_writes", exp_q.size(), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start_i  = 1'b0;
    halted_i = 1'b0;
    fill_mem(1'b1);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset.state", dbg_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_restore(0, 1'b0, 0);                          // nominal, A5A5 pattern
    run_restore(5, 1'b0, 0);                          // delayed acknowledge
    run_restore(-1, 1'b0, 0);                         // halt timeout
    fill_mem(1'b0);
    run_restore(int'($urandom_range(0, 4)), 1'b1, 0); // start_i spam ignored
    run_restore(0, 1'b0, 10);                         // reset mid-copy
    fill_mem(1'b1);
    run_restore(0, 1'b0, 0);                          // full restore after reset
    for (int i = 0; i < 256; i++) begin
      fill_mem(1'b0);
      run_restore(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
    end
    check("saturated_cnt", restore_cnt_o, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sgpr_restore.md
# sgpr_restore

Recovery sequencer on the read side of the shared register file (SGPR). On a lockstep mismatch it halts both cores and reads every architectural register (x1..x31) out of the SGPR. It broadcasts each value on a common write port into both cores' local register files. The result is that both cores resume from the last agreed-upon state. It sits between the comparator mismatch signal and the two cores' register-file write ports.

## Interface
Parameters:
- ADDR_WIDTH, 5, register address width
- DATA_WIDTH, 32, register data width
- NUM_REGS, 32, registers in file; x0 never copied
- HALT_TIMEOUT, 15, max cycles to wait for halt acknowledge

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  recovery request (mismatch), sampled in IDLE only
- halt_o  out  1  hold both cores
- halted_i  in  1  both cores report halted
- raddr_o  out  ADDR_WIDTH  SGPR read address
- rdata_i  in  DATA_WIDTH  SGPR read data, combinational from raddr_o
- we_o  out  1  write enable to both core register files
- waddr_o  out  ADDR_WIDTH  write address
- wdata_o  out  DATA_WIDTH  write data
- busy_o  out  1  not IDLE
- done_o  out  1  one-cycle pulse, restore complete
- fail_o  out  1  one-cycle pulse, halt acknowledge timed out
- restore_cnt_o  out  8  completed restores, saturating

## Operation
- The FSM has six states: IDLE, HALT, COPY, DRAIN, DONE, FAIL. All outputs are registered or decoded from the registered state.
- **IDLE:**
  - Outputs are low.
  - raddr_o = 0.
  - A start_i=1 transition goes to HALT, clears the timeout timer and loads the address counter with 1.
- **HALT:**
  - halt_o=1.
  - If halted_i=1, go to COPY.
  - Otherwise, increment the timer. When the timer reaches HALT_TIMEOUT, go to FAIL.
- **COPY:**
  - halt_o=1.
  - raddr_o = counter.
  - Each cycle, rdata_i and the address are captured into the write-output registers with we_o=1 on the next cycle.
  - The counter increments each cycle.
  - After reading NUM_REGS-1, go to DRAIN.
- **DRAIN:** halt_o=1 and the final write (address NUM_REGS-1) is presented.
- **DONE:**
  - halt_o=1.
  - done_o=1 and we_o=0.
  - restore_cnt_o increments, saturating at 255.
  - Next state is IDLE.
- **FAIL:**
  - fail_o=1 and halt_o=0.
  - No writes are issued.
  - Next state is IDLE.
- start_i is ignored outside IDLE, including on the DONE/FAIL cycle; no request is queued.
- halted_i is ignored outside HALT. Deassertion during COPY does not abort the sequence.
- x0 is never read or written. Address 0 never appears on waddr_o with we_o=1.
- waddr_o and wdata_o hold their last values when we_o=0. Only we_o qualifies them.

## Timing
- **Reset values:**
  - State is IDLE.
  - halt_o, we_o, busy_o, done_o and fail_o are 0.
  - raddr_o, waddr_o, wdata_o and restore_cnt_o are 0.
  - The timer and counter are 0.
- **Reset mid-operation:** the block returns immediately to the reset values. A partial restore is abandoned, and halt_o drops asynchronously.
- **Nominal sequence** (start_i at cycle 0, halted_i already high):
  - HALT at cycle 1.
  - COPY over cycles 2–32, with raddr_o running 1..31.
  - we_o=1 over cycles 3–33, with waddr_o running 1..31. Write latency is 1 cycle after read.
  - DRAIN at cycle 33.
  - DONE at cycle 34.
  - IDLE at cycle 35.
- **Totals:** busy_o is high for cycles 1–34. halt_o is high for cycles 1–34.
- **Delayed acknowledge:** each extra cycle before halted_i delays everything by one cycle.
- **Timeout:** with halted_i never high, HALT lasts HALT_TIMEOUT cycles, then FAIL for 1 cycle, then IDLE.

## Structure
- Package sgpr_restore_pkg holds:
  - the state typedef enum (IDLE, HALT, COPY, DRAIN, DONE, FAIL);
  - the restore-counter width constant (8).
- Single module, no sub-modules. The counter, timer and FSM are small enough to keep inline.

## Test plan
- Reset, then preload SGPR with xN = 0xA5A50000+N; pulse start_i with halted_i=1 -> exactly 31 writes, waddr 1..31 in order, wdata 0xA5A50001..0xA5A5001F, done_o at cycle 34, restore_cnt_o=1.
- halted_i asserted 5 cycles after entering HALT -> first write shifted by 5 cycles, identical data, no write before halted_i.
- halted_i held 0 -> fail_o pulse after 15 HALT cycles, zero writes, halt_o low on the FAIL cycle, restore_cnt_o unchanged.
- start_i pulsed repeatedly during COPY and on the DONE cycle -> ignored, exactly one restore, returns to IDLE.
- rst_n asserted at the 10th write -> all outputs 0 immediately; a new start_i then completes a full restore of 31 writes.
- 256 back-to-back restores -> restore_cnt_o saturates at 255; waddr_o never 0 with we_o=1.
